// File: rtl/vga_scandoubler_pkg.sv
// Shared constants and types for the PAL-to-VGA line doubler.
package vga_scandoubler_pkg;

    localparam int unsigned DEF_LINE_LEN = 448;
    localparam int unsigned DEF_HS_START = 360;
    localparam int unsigned DEF_HS_LEN   = 54;
    localparam int unsigned RGB_W        = 9;
    localparam int unsigned HCNT_W       = 9;
    localparam int unsigned BUF_AW       = HCNT_W + 1;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_scandoubler_linebuf.sv
// Two-bank line buffer: simple dual-port RAM with a registered read port.
module scandbl_linebuf
    import vga_scandoubler_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  rgb_t              wdata,
    input  logic [BUF_AW-1:0] raddr,
    output rgb_t              rdata
);

    localparam int unsigned DEPTH = 1 << BUF_AW;

    rgb_t mem [DEPTH];

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_scandoubler.sv
// Captures PAL scanlines into one bank and replays the other bank twice at
// VGA rate with regenerated hsync; bypass forwards the PAL signals unchanged.
module vga_scandoubler
    import vga_scandoubler_pkg::*;
#(
    parameter int unsigned LINE_LEN = DEF_LINE_LEN,
    parameter int unsigned HS_START = DEF_HS_START,
    parameter int unsigned HS_LEN   = DEF_HS_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_in,
    input  logic              scandbl_en,
    input  logic [HCNT_W-1:0] hcnt,
    input  logic [2:0]        ri,
    input  logic [2:0]        gi,
    input  logic [2:0]        bi,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              csync_in,
    output logic [2:0]        ro,
    output logic [2:0]        go,
    output logic [2:0]        bo,
    output logic              hsync_o,
    output logic              vsync_o
);

    localparam logic [HCNT_W-1:0] RCNT_LAST = HCNT_W'(LINE_LEN - 1);
    localparam logic [HCNT_W:0]   LEN_X     = (HCNT_W + 1)'(LINE_LEN);
    localparam logic [HCNT_W:0]   HS_LO     = (HCNT_W + 1)'(HS_START);
    localparam logic [HCNT_W:0]   HS_HI     = (HCNT_W + 1)'(HS_START + HS_LEN);

    logic [HCNT_W-1:0] hcnt_prev_q, hcnt_prev_d;
    logic [HCNT_W-1:0] rcnt_q, rcnt_d;
    logic [HCNT_W-1:0] rcnt_p1_q;
    bank_t             wbank_q, wbank_d;
    logic              vs_r_q, vs_r_d;
    rgb_t              col_q, col_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;

    logic              line_start;
    logic              we;
    logic              hs_act;
    logic [BUF_AW-1:0] waddr;
    logic [BUF_AW-1:0] raddr;
    rgb_t              pix_in;
    rgb_t              rd_pix;

    logic              unused_hsync_in;
    assign unused_hsync_in = hsync_in;

    // Line-start detect, bank/read-counter control and output mux.
    always_comb begin
        pix_in      = rgb_t'({ri, gi, bi});
        line_start  = ce_in && (hcnt == '0) && (hcnt_prev_q != '0);
        hcnt_prev_d = ce_in ? hcnt : hcnt_prev_q;
        wbank_d     = line_start ? bank_t'(~wbank_q) : wbank_q;
        vs_r_d      = line_start ? vsync_in : vs_r_q;
        rcnt_d      = rcnt_q + HCNT_W'(1);
        if (line_start || (rcnt_q == RCNT_LAST)) begin
            rcnt_d = '0;
        end

        // Pixel 0 of a new line already belongs to the freshly selected bank.
        we    = ce_in && ({1'b0, hcnt} < LEN_X);
        waddr = {1'(wbank_d), hcnt};
        raddr = {1'(~wbank_q), rcnt_q};

        hs_act = ({1'b0, rcnt_p1_q} >= HS_LO) && ({1'b0, rcnt_p1_q} < HS_HI);

        col_d = pix_in;
        hs_d  = csync_in;
        vs_d  = vsync_in;
        if (scandbl_en) begin
            col_d = hs_act ? '0 : rd_pix;
            hs_d  = ~hs_act;
            vs_d  = vs_r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_prev_q <= '0;
            wbank_q     <= BANK_0;
            rcnt_q      <= '0;
            rcnt_p1_q   <= '0;
            vs_r_q      <= 1'b1;
            col_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
        end else begin
            hcnt_prev_q <= hcnt_prev_d;
            wbank_q     <= wbank_d;
            rcnt_q      <= rcnt_d;
            rcnt_p1_q   <= rcnt_q;
            vs_r_q      <= vs_r_d;
            col_q       <= col_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    scandbl_linebuf u_linebuf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (pix_in),
        .raddr (raddr),
        .rdata (rd_pix)
    );

    assign ro      = col_q.r;
    assign go      = col_q.g;
    assign bo      = col_q.b;
    assign hsync_o = hs_q;
    assign vsync_o = vs_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// Directed bench for vga_scandoubler with a bench-side PAL pixel generator.
module tb_vga_scandoubler;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce_in;
    logic       scandbl_en;
    logic [8:0] hcnt;
    logic [2:0] ri, gi, bi;
    logic       hsync_in, vsync_in, csync_in;
    logic [2:0] ro, go, bo;
    logic       hsync_o, vsync_o;

    int n_vec   = 0;
    int n_err   = 0;
    int edge_n  = 0;
    int ls_edge = 0;
    int line_no = 0;
    int gen_len = 448;
    bit pat_en  = 1'b1;

    vga_scandoubler dut (
        .clk        (clk),
        .rst        (rst),
        .ce_in      (ce_in),
        .scandbl_en (scandbl_en),
        .hcnt       (hcnt),
        .ri         (ri),
        .gi         (gi),
        .bi         (bi),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .csync_in   (csync_in),
        .ro         (ro),
        .go         (go),
        .bo         (bo),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, edges=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    // One clk: outputs observed here reflect posedge number edge_n.
    task automatic tick();
        @(negedge clk);
        edge_n++;
        if (ce_in) begin
            hcnt  = (int'(hcnt) == gen_len - 1) ? 9'd0 : hcnt + 9'd1;
            ce_in = 1'b0;
        end else begin
            ce_in = 1'b1;
        end
        if (ce_in && hcnt == 9'd0) begin
            ls_edge = edge_n + 1;
            line_no++;
        end
        if (pat_en) {ri, gi, bi} = 9'(int'(hcnt) + 7 * line_no);
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) tick();
    endtask

    task automatic wait_line();
        int start;
        start = line_no;
        while (line_no == start) tick();
    endtask

    task automatic test_reset();
        int l0, r;
        tick();
        tick();
        rst = 1'b0;
        wait_line();
        l0 = ls_edge;
        wait_edge(l0 + 370);
        n_vec++;
        if (hsync_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pre_hs: hsync_o=%b expected 0", hsync_o);
        end
        n_vec++;
        if (vsync_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pre_vs: vsync_o=%b expected 0", vsync_o);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({ro, go, bo} !== 9'd0 || hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
                n_err++;
                $display("FAIL reset_vals[%0d]: rgb=%03h hs=%b vs=%b expected rgb=000 hs=1 vs=1",
                         i, {ro, go, bo}, hsync_o, vsync_o);
            end
        end
        rst      = 1'b0;
        vsync_in = 1'b1;
        r        = edge_n;
        wait_edge(r + 361);
        n_vec++;
        if (hsync_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rcnt359: hsync_o=%b expected 1", hsync_o);
        end
        tick();
        n_vec++;
        if (hsync_o !== 1'b0 || vsync_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rcnt360: hs=%b vs=%b expected hs=0 vs=1", hsync_o, vsync_o);
        end
    endtask

    task automatic test_capture_replay();
        int ls0, lid, k;
        logic [8:0] exp_c;
        logic       exp_hs;
        wait_line();
        wait_line();
        ls0 = ls_edge;
        lid = line_no - 1;
        for (int d = 0; d < 896; d++) begin
            wait_edge(ls0 + 2 + d);
            k      = d % 448;
            exp_hs = !(k >= 360 && k < 414);
            exp_c  = exp_hs ? 9'(k + 7 * lid) : 9'd0;
            n_vec++;
            if ({ro, go, bo} !== exp_c || hsync_o !== exp_hs) begin
                n_err++;
                $display("FAIL replay d=%0d: rgb=%03h hs=%b expected rgb=%03h hs=%b",
                         d, {ro, go, bo}, hsync_o, exp_c, exp_hs);
            end
        end
    endtask

    task automatic test_hsync();
        int ls1, f1, r1, f2, lows, bad_col;
        logic prev_hs;
        ls1     = ls_edge;
        f1      = -1;
        r1      = -1;
        f2      = -1;
        lows    = 0;
        bad_col = 0;
        prev_hs = 1'b1;
        for (int d = 0; d < 896; d++) begin
            wait_edge(ls1 + 2 + d);
            if (prev_hs === 1'b1 && hsync_o === 1'b0) begin
                if (f1 < 0) f1 = d;
                else if (f2 < 0) f2 = d;
            end
            if (prev_hs === 1'b0 && hsync_o === 1'b1 && r1 < 0) r1 = d;
            if (hsync_o === 1'b0) begin
                lows++;
                if ({ro, go, bo} !== 9'd0) bad_col++;
            end
            prev_hs = hsync_o;
        end
        n_vec++;
        if (f1 != 360) begin
            n_err++;
            $display("FAIL hs_start: fell %0d clk after line start, expected 362", f1 + 2);
        end
        n_vec++;
        if (r1 - f1 != 54) begin
            n_err++;
            $display("FAIL hs_width: %0d clk, expected 54", r1 - f1);
        end
        n_vec++;
        if (f2 - f1 != 448) begin
            n_err++;
            $display("FAIL hs_period: %0d clk, expected 448", f2 - f1);
        end
        n_vec++;
        if (lows != 108) begin
            n_err++;
            $display("FAIL hs_lowcount: %0d clk low per input line, expected 108", lows);
        end
        n_vec++;
        if (bad_col != 0) begin
            n_err++;
            $display("FAIL hs_blank: %0d nonzero pixels during hsync, expected 0", bad_col);
        end
    endtask

    task automatic test_early_wrap();
        int a, ls3, k, lid;
        logic [8:0] exp_c;
        logic       exp_hs;
        gen_len = 384;
        a       = line_no;
        wait_line();
        ls3 = ls_edge;
        for (int d = 0; d < 771; d++) begin
            wait_edge(ls3 + 2 + d);
            if (d < 768) begin
                k   = d % 448;
                lid = a;
            end else begin
                k   = d - 768;
                lid = a + 1;
            end
            exp_hs = !(k >= 360 && k < 414);
            exp_c  = exp_hs ? 9'(k + 7 * lid) : 9'd0;
            n_vec++;
            if (hsync_o !== exp_hs || ((k < 384 || !exp_hs) && {ro, go, bo} !== exp_c)) begin
                n_err++;
                $display("FAIL early_wrap d=%0d: rgb=%03h hs=%b expected rgb=%03h hs=%b",
                         d, {ro, go, bo}, hsync_o, exp_c, exp_hs);
            end
        end
        gen_len = 448;
    endtask

    task automatic test_vsync();
        int l;
        wait_line();
        l = ls_edge;
        wait_edge(l + 400);
        vsync_in = 1'b0;
        for (int e = l + 401; e < l + 896; e++) begin
            wait_edge(e);
            n_vec++;
            if (vsync_o !== 1'b1) begin
                n_err++;
                $display("FAIL vs_hold_hi edge+%0d: vsync_o=%b expected 1", e - l, vsync_o);
            end
        end
        wait_edge(l + 896);
        n_vec++;
        if (vsync_o !== 1'b0) begin
            n_err++;
            $display("FAIL vs_fall: vsync_o=%b expected 0 at line start", vsync_o);
        end
        wait_edge(l + 896 + 300);
        vsync_in = 1'b1;
        for (int e = l + 896 + 301; e < l + 1792; e++) begin
            wait_edge(e);
            n_vec++;
            if (vsync_o !== 1'b0) begin
                n_err++;
                $display("FAIL vs_hold_lo edge+%0d: vsync_o=%b expected 0", e - l, vsync_o);
            end
        end
        wait_edge(l + 1792);
        n_vec++;
        if (vsync_o !== 1'b1) begin
            n_err++;
            $display("FAIL vs_rise: vsync_o=%b expected 1 at line start", vsync_o);
        end
    endtask

    task automatic test_bypass();
        logic [10:0] exp_v;
        scandbl_en     = 1'b0;
        pat_en         = 1'b0;
        {ri, gi, bi}   = {3'b101, 3'b010, 3'b111};
        csync_in       = 1'b0;
        vsync_in       = 1'b1;
        exp_v          = {ri, gi, bi, csync_in, vsync_in};
        for (int i = 0; i < 12; i++) begin
            tick();
            n_vec++;
            if ({ro, go, bo, hsync_o, vsync_o} !== exp_v) begin
                n_err++;
                $display("FAIL bypass[%0d]: rgb/hs/vs=%03h/%b/%b expected %03h/%b/%b",
                         i, {ro, go, bo}, hsync_o, vsync_o, exp_v[10:2], exp_v[1], exp_v[0]);
            end
            csync_in = ~csync_in;
            vsync_in = ((i % 4) == 1) ? 1'b0 : 1'b1;
            if ((i & 4) != 0) {ri, gi, bi} = {3'b010, 3'b101, 3'b000};
            else              {ri, gi, bi} = {3'b101, 3'b010, 3'b111};
            exp_v = {ri, gi, bi, csync_in, vsync_in};
        end
    endtask

    initial begin
        rst        = 1'b1;
        ce_in      = 1'b0;
        scandbl_en = 1'b1;
        hcnt       = 9'd300;
        {ri, gi, bi} = 9'd0;
        hsync_in   = 1'b1;
        vsync_in   = 1'b0;
        csync_in   = 1'b1;

        test_reset();
        test_capture_replay();
        test_hsync();
        test_early_wrap();
        test_vsync();
        test_bypass();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scandoubler.md
# vga_scandoubler

Line-doubling stage directly downstream of the PAL sync generator. Captures each 15.6 kHz scanline (RGB 3:3:3 at the 7 MHz pixel rate, addressed by the generator's horizontal counter) into one bank of a two-line buffer. Meanwhile it plays the other bank back twice at 14 MHz, producing 31.25 kHz VGA-rate RGB plus regenerated horizontal sync. A bypass mode forwards the PAL signals unchanged for RGB/SCART monitors.

## Interface
- LINE_LEN, 448: input pixels per scanline (hcnt range 0..LINE_LEN-1); also output clocks per doubled line.
- HS_START, 360: output clock index (read address) where VGA hsync asserts.
- HS_LEN, 54: VGA hsync width in clk cycles (~3.8 µs at 14 MHz).
- clk  in  1  14 MHz master clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- ce_in  in  1  input pixel strobe, high every other clk (7 MHz).
- scandbl_en  in  1  1 = doubled VGA output; 0 = bypass.
- hcnt  in  9  horizontal counter from the sync generator.
- ri, gi, bi  in  3 each  input pixel colour.
- hsync_in, vsync_in, csync_in  in  1 each  PAL syncs, active-low.
- ro, go, bo  out  3 each  output colour.
- hsync_o, vsync_o  out  1 each  output syncs, active-low (hsync_o carries csync_in in bypass).

## Operation
- Write side, on clk with ce_in=1: write {ri,gi,bi} at address hcnt into bank wbank. Writes with hcnt ≥ LINE_LEN are dropped.
- Line start: ce_in=1 and hcnt==0, with the previously sampled hcnt ≠ 0. On a line start:
  - toggle wbank;
  - load rcnt with 0;
  - latch vsync_in into vs_r.
- Read side, every clk: read bank ~wbank at address rcnt. rcnt increments and wraps LINE_LEN-1→0, so every captured line plays out exactly twice per input line (2×LINE_LEN clk).
- Line start and rcnt wrap in the same cycle: line start wins, and rcnt loads 0.
- Short input line (hcnt wraps early, e.g. after a mode change): swap anyway. Buffer entries not rewritten keep stale data. No other recovery.
- hsync_o (doubled) = 0 while HS_START ≤ rcnt_d < HS_START+HS_LEN, where rcnt_d is rcnt delayed to align with the pixel data. HS_START+HS_LEN must be ≤ LINE_LEN; no wrap support.
- Colour is forced to 0 while hsync_o=0.
- vsync_o = vs_r (changes only at line boundaries).
- Bypass (scandbl_en=0): registered copies of ri/gi/bi, csync_in→hsync_o, vsync_in→vsync_o, all with 1 clk latency. Buffer writes continue, so switching modes needs no resync.
- scandbl_en is sampled every clk. Switching mid-line may produce one malformed line; no glitch suppression is required.

## Timing
- Reset values: ro=go=bo=0, hsync_o=1, vsync_o=1, wbank=0, rcnt=0, vs_r=1, sampled hcnt=0.
- Reset mid-line is honoured in the same cycle. Buffer contents are not cleared, so up to two lines of stale pixels are acceptable after reset.
- Doubled path latency is 2 clk from rcnt to outputs: 1 cycle synchronous RAM read, then the output register. hsync_o is generated from rcnt delayed 2 clk so it stays aligned with the colour.
- Write-to-read: a pixel captured on line N appears in both output lines played during input line N+1.
- No read/write collision is possible: the two banks are always distinct.

## Structure
- Package vga_scandoubler_pkg: default LINE_LEN, HS_START, HS_LEN; RGB333 width constant (9); bank select type.
- Sub-module scandbl_linebuf: simple dual-port RAM, 2×512×9. One write port (we, waddr[9:0]) and one registered read port (raddr[9:0]); bank is the address MSB. Must infer block RAM.
- Top holds the line-start detector, wbank, rcnt, the sync/blank pipeline and the bypass mux.

## Test plan
- Reset: assert rst 3 clk at arbitrary hcnt → all outputs at reset values next clk, rcnt=0, wbank=0.
- Capture/replay: write line with pixel = hcnt[8:0]&9'h1FF pattern, then next line → during next input line ro/go/bo show hcnt pattern twice, sample at rcnt=k is k's colour, exactly 2 clk after rcnt=k.
- Hsync: steady lines → hsync_o low for exactly 54 clk starting 362 clk after each doubled-line start, period 448 clk, colour 0 while low.
- Early wrap: input line wraps at hcnt=383 → rcnt reloads 0 at that line start, no doubled line exceeds 448 clk, bank toggles.
- Bypass: scandbl_en=0, ri/gi/bi=3'b101/3'b010/3'b111, csync_in toggling → outputs equal inputs 1 clk later, hsync_o follows csync_in.
- Vsync: vsync_in falls mid-line → vsync_o falls at the next line start only.
